gpio_cycle_scheduler: RTL and testbench

Command-queue controller that sequences the GPIO cycler (prescaled clock divider, 0..34 pin counter, and decoder).
- Software or a loader pushes run commands, each a prescaler plus a pass count, into a small FIFO.
- The block drives the cycler's `enable`/`stop`/`prescaler` inputs and counts the cycler's `done` pulses.
- It raises a sticky interrupt when the queued batch finishes.
- It sits between the Wishbone/LA configuration registers and the cycler.

---
 rtl/gpio_cycle_scheduler.sv | 143 ++++++++++++++
 tb/tb_gpio_cycle_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cycle_scheduler.sv
// Command-queue sequencer for the GPIO cycler: FIFO of {prescaler, loops} run commands
// driving enable/stop/prescaler, with a sticky batch-complete irq. Macro GPIO_SCHED_LOOPS_EN enables multi-pass entries.
module gpio_cycle_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [13:0]              cmd_prescaler,
  input  logic [3:0]               cmd_loops,
  input  logic                     abort,
  input  logic                     cyc_done,
  output logic                     cyc_enable,
  output logic                     cyc_stop,
  output logic [13:0]              cyc_prescaler,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [3:0]               loops_left,
  output logic                     irq,
  input  logic                     irq_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [13:0]   mem_pre [DEPTH];
  logic          aborted;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          irq_set;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count < CW'(DEPTH)) && !abort;
  // A zero-prescaler command completes the handshake but is dropped.
  assign push       = cmd_valid && cmd_ready && (cmd_prescaler != '0);
  assign pop        = !abort && !fifo_empty && (state == IDLE || state == DRAIN);
  assign irq_set    = (state == DRAIN) && !abort && fifo_empty && !aborted;

  assign fifo_count = count;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign cyc_enable = (state == RUN);
  assign cyc_stop   = (state == LOAD) || (state == DRAIN);

  // NOTE: FIFO storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_pre[wr_ptr] <= cmd_prescaler;
  end

`ifdef GPIO_SCHED_LOOPS_EN
  logic [3:0] mem_loops [DEPTH];
  logic [3:0] loops_q;

  always_ff @(posedge clk) begin
    if (push) mem_loops[wr_ptr] <= cmd_loops;
  end

  assign loops_left = loops_q;
`else
  logic unused_loops;
  assign unused_loops = ^cmd_loops;
  assign loops_left   = {3'b000, state == RUN};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      cyc_prescaler <= '0;
      irq           <= 1'b0;
      aborted       <= 1'b0;
`ifdef GPIO_SCHED_LOOPS_EN
      loops_q       <= '0;
`endif
    end else begin
      if (pop) begin
        cyc_prescaler <= mem_pre[rd_ptr];
`ifdef GPIO_SCHED_LOOPS_EN
        loops_q       <= (mem_loops[rd_ptr] == '0) ? 4'd1 : mem_loops[rd_ptr];
`endif
      end

      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;

      if (abort) begin
        // An aborted batch still passes through DRAIN so the cycler sees a stop, but raises no irq.
        aborted <= (state == LOAD) || (state == RUN);
        state   <= ((state == LOAD) || (state == RUN)) ? DRAIN : IDLE;
`ifdef GPIO_SCHED_LOOPS_EN
        loops_q <= '0;
`endif
      end else begin
        case (state)
          IDLE: if (!fifo_empty) state <= LOAD;
          LOAD: state <= RUN;
          RUN: begin
            if (cyc_done) begin
`ifdef GPIO_SCHED_LOOPS_EN
              loops_q <= loops_q - 4'd1;
              if (loops_q <= 4'd1) state <= DRAIN;
`else
              state <= DRAIN;
`endif
            end
          end
          DRAIN: begin
            aborted <= 1'b0;
            state   <= fifo_empty ? IDLE : LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_cycle_scheduler.sv
// Self-checking bench for gpio_cycle_scheduler: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_gpio_cycle_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] cmd_prescaler;
  logic [3:0]  cmd_loops;
  logic        abort;
  logic        cyc_done;
  logic        cyc_enable;
  logic        cyc_stop;
  logic [13:0] cyc_prescaler;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [3:0]  loops_left;
  logic        irq;
  logic        irq_clr;

  gpio_cycle_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_prescaler(cmd_prescaler), .cmd_loops(cmd_loops), .abort(abort),
    .cyc_done(cyc_done), .cyc_enable(cyc_enable), .cyc_stop(cyc_stop),
    .cyc_prescaler(cyc_prescaler), .busy(busy), .fifo_count(fifo_count),
    .loops_left(loops_left), .irq(irq), .irq_clr(irq_clr)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending commands in a queue, phase 0=idle 1=load 2=run 3=drain.
  typedef struct { int pre; int passes; } ent_t;
  ent_t mq[$];
  int   m_st, m_pre, m_left;
  bit   m_irq, m_killed;
  int   in_v, in_p, in_l, in_ab, in_dn, in_clr;

  function automatic int passes_of(input int l);
`ifdef GPIO_SCHED_LOOPS_EN
    return (l == 0) ? 1 : l;
`else
    return 1;
`endif
  endfunction

  function automatic bit model_ready();
    return (mq.size() < DEPTH) && (in_ab == 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_st = 0; m_pre = 0; m_left = 0; m_irq = 0; m_killed = 0;
  endtask

  task automatic model_step();
    int   cnt;
    bit   take, set_irq;
    ent_t e;
    cnt     = mq.size();
    take    = (in_v != 0) && model_ready() && (in_p != 0);
    set_irq = 0;
    if (in_ab != 0) begin
      mq.delete();
      m_left = 0;
      if (m_st == 1 || m_st == 2) begin m_st = 3; m_killed = 1; end
      else begin m_st = 0; m_killed = 0; end
    end else begin
      case (m_st)
        0: if (cnt > 0) begin e = mq.pop_front(); m_pre = e.pre; m_left = e.passes; m_st = 1; end
        1: m_st = 2;
        2: if (in_dn != 0) begin m_left--; if (m_left == 0) m_st = 3; end
        default: begin
          if (cnt > 0) begin e = mq.pop_front(); m_pre = e.pre; m_left = e.passes; m_st = 1; end
          else begin m_st = 0; set_irq = !m_killed; end
          m_killed = 0;
        end
      endcase
      if (take) mq.push_back('{in_p, passes_of(in_l)});
    end
    if (set_irq) m_irq = 1;
    else if (in_clr != 0) m_irq = 0;
  endtask

  task automatic compare_all();
    int exp_left;
`ifdef GPIO_SCHED_LOOPS_EN
    exp_left = m_left;
`else
    exp_left = (m_st == 2) ? 1 : 0;
`endif
    check("cyc_enable", int'(cyc_enable), int'(m_st == 2));
    check("cyc_stop", int'(cyc_stop), int'(m_st == 1 || m_st == 3));
    check("cyc_prescaler", int'(cyc_prescaler), m_pre);
    check("busy", int'(busy), int'(m_st != 0 || mq.size() != 0));
    check("fifo_count", int'(fifo_count), mq.size());
    check("loops_left", int'(loops_left), exp_left);
    check("irq", int'(irq), int'(m_irq));
  endtask

  // Called just after an active edge: drive inputs, check cmd_ready, clock once, compare.
  task automatic cycle(input int v, input int p, input int l, input int ab, input int dn, input int clr);
    in_v = v; in_p = p; in_l = l; in_ab = ab; in_dn = dn; in_clr = clr;
    cmd_valid = 1'(v); cmd_prescaler = 14'(p); cmd_loops = 4'(l);
    abort = 1'(ab); cyc_done = 1'(dn); irq_clr = 1'(clr);
    #1;
    check("cmd_ready", int'(cmd_ready), int'(model_ready()));
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 8 && !cyc_enable; i++) cycle(0, 0, 0, 0, 0, 0);
    check("wait_run", int'(cyc_enable), 1);
  endtask

  typedef struct {
    int v, p, l, d, c;
    int e_stop, e_en, e_busy, e_cnt, e_irq;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   got_pre[$];
    bit   prev_en;
    int   exp_left;

    tbl[0] = '{1, 1, 1, 0, 0,  0, 0, 1, 1, 0};
    tbl[1] = '{0, 0, 0, 0, 0,  1, 0, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 0,  1, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 3, 0, 0,  0, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0};

    nrst = 1'b0;
    cmd_valid = 0; cmd_prescaler = '0; cmd_loops = '0; abort = 0; cyc_done = 0; irq_clr = 0;
    in_v = 0; in_p = 0; in_l = 0; in_ab = 0; in_dn = 0; in_clr = 0;
    model_reset();
    #120;
    compare_all();
    check("reset_cmd_ready", int'(cmd_ready), 1);
    nrst = 1'b1;

    // Directed table: single pass, irq set/clear, zero-prescaler drop, stray done.
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].p, tbl[i].l, 0, tbl[i].d, tbl[i].c);
      check("tbl_stop", int'(cyc_stop), tbl[i].e_stop);
      check("tbl_enable", int'(cyc_enable), tbl[i].e_en);
      check("tbl_busy", int'(busy), tbl[i].e_busy);
      check("tbl_count", int'(fifo_count), tbl[i].e_cnt);
      check("tbl_irq", int'(irq), tbl[i].e_irq);
    end

    // Two-pass entry runs to completion and raises irq.
    cycle(1, 1, 2, 0, 0, 0);
    wait_run();
    for (int i = 0; i < 20 && busy; i++) cycle(0, 0, 0, 0, int'(cyc_enable), 0);
    check("batch_irq", int'(irq), 1);
    check("batch_idle", int'(busy), 0);

    // Fill the FIFO behind a running entry; a fifth push must be refused.
    cycle(1, 10, 1, 0, 0, 0);
    wait_run();
    for (int i = 0; i < 4; i++) cycle(1, 11 + i, 1, 0, 0, 0);
    check("full_count", int'(fifo_count), 4);
    check("full_ready", int'(cmd_ready), 0);
    cycle(1, 15, 1, 0, 0, 0);
    check("full_ignored", int'(fifo_count), 4);
    got_pre.push_back(int'(cyc_prescaler));
    prev_en = 1;
    for (int i = 0; i < 60 && busy; i++) begin
      cycle(0, 0, 0, 0, int'(cyc_enable), 0);
      if (cyc_enable && !prev_en) got_pre.push_back(int'(cyc_prescaler));
      prev_en = cyc_enable;
    end
    check("order_len", got_pre.size(), 5);
    for (int i = 0; i < 5; i++)
      check("order_pre", (i < got_pre.size()) ? got_pre[i] : -1, 10 + i);

    // Abort mid-run with three queued: flush, DRAIN, then IDLE without irq.
    cycle(1, 20, 1, 0, 0, 1);
    wait_run();
    for (int i = 0; i < 3; i++) cycle(1, 21 + i, 1, 0, 0, 0);
    check("abort_pre_count", int'(fifo_count), 3);
    cycle(1, 24, 1, 1, 0, 0);
    check("abort_drain", int'({cyc_stop, cyc_enable}), 2);
    check("abort_flush", int'(fifo_count), 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("abort_idle", int'(busy), 0);
    check("abort_noirq", int'(irq), 0);

    // irq set wins over a same-cycle clear.
    cycle(1, 7, 1, 0, 0, 0);
    wait_run();
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("irq_set_wins", int'(irq), 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("irq_cleared", int'(irq), 0);

    // Asynchronous reset mid-run, then a loops=0 entry runs one pass.
    cycle(1, 3, 3, 0, 0, 0);
    wait_run();
`ifdef GPIO_SCHED_LOOPS_EN
    exp_left = 3;
`else
    exp_left = 1;
`endif
    check("run_loops_left", int'(loops_left), exp_left);
    #10 nrst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_cmd_ready", int'(cmd_ready), 1);
    #20 nrst = 1'b1;
    cycle(1, 5, 0, 0, 0, 0);
    wait_run();
    check("zero_loops_left", int'(loops_left), 1);
    cycle(0, 0, 0, 0, 1, 0);
    check("zero_loops_drain", int'(cyc_stop), 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("zero_loops_irq", int'(irq), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(int'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 29) == 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 5) == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
